// File: rtl/module_seg7_scan_n.sv
// rtl/module_seg7_scan_n.sv - double-buffered N-digit hex 7-segment scan controller with LZ blanking and PWM
module module_seg7_scan_n #(
  parameter int N_DIGITS     = 8,
  parameter int DIGIT_CYCLES = 10000,
  parameter int PWM_BITS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clk_en_i,
  input  logic                  wr_en_i,
  input  logic                  sel_i,
  input  logic [4*N_DIGITS-1:0] data_a_i,
  input  logic [4*N_DIGITS-1:0] data_b_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  blank_lz_i,
  input  logic [PWM_BITS-1:0]   bright_i,
  output logic [6:0]            display_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   display_select_o,
  output logic                  frame_o
);

  localparam int TW = $clog2(DIGIT_CYCLES);
  localparam int DW = $clog2(N_DIGITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] r_shadow_data;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic                  r_pending;
  logic [4*N_DIGITS-1:0] r_active_data;
  logic [N_DIGITS-1:0]   r_active_dp;
  logic [TW-1:0]         r_timer;
  logic [DW-1:0]         r_digit;
  logic [PWM_BITS-1:0]   r_pwm;
  logic [6:0]            r_display;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_select;
  logic                  r_frame;

  logic                  w_timer_wrap;
  logic                  w_frame;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_blank;
  logic                  w_run;
  logic [N_DIGITS-1:0]   w_onehot;
  logic                  w_anode_on;

  assign w_timer_wrap = (r_timer == TIMER_LAST);
  assign w_frame      = w_timer_wrap && (r_digit == DIGIT_LAST);
  assign w_nibble     = r_active_data[{r_digit, 2'b00} +: 4];
  assign w_onehot     = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_digit;
  assign w_anode_on   = !w_blank[r_digit] && (r_pwm <= bright_i);

  // Shadow takes writes at any time; active copies it only at a frame boundary so the display never tears
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pending     <= 1'b0;
      r_active_data <= '0;
      r_active_dp   <= '0;
    end else if (clk_en_i) begin
      if (wr_en_i) begin
        r_shadow_data <= sel_i ? data_b_i : data_a_i;
        r_shadow_dp   <= dp_i;
      end
      if (w_frame && r_pending) begin
        r_active_data <= r_shadow_data;
        r_active_dp   <= r_shadow_dp;
      end
      // A write on the boundary cycle keeps pending set for the next frame
      if (wr_en_i) begin
        r_pending <= 1'b1;
      end else if (w_frame) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Slot timer, digit index and free-running PWM counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_timer <= '0;
      r_digit <= '0;
      r_pwm   <= '0;
    end else if (clk_en_i) begin
      r_pwm <= r_pwm + 1'b1;
      if (w_timer_wrap) begin
        r_timer <= '0;
        r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Leading-zero mask from the top digit down; digit 0 is never blanked
  always_comb begin
    w_blank = '0;
    w_run   = blank_lz_i;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_run      = w_run && (r_active_data[4*i +: 4] == 4'h0) && !r_active_dp[i];
      w_blank[i] = w_run;
    end
  end

  // Hex glyph decode, active-high gfedcba
  always_comb begin
    w_seg = 7'h00;
    case (w_nibble)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  // Registered active-low pins; frame pulse is forced low while disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_display <= 7'h7F;
      r_dp      <= 1'b1;
      r_select  <= '1;
      r_frame   <= 1'b0;
    end else if (clk_en_i) begin
      r_display <= ~w_seg;
      r_dp      <= ~r_active_dp[r_digit];
      r_select  <= w_anode_on ? ~w_onehot : '1;
      r_frame   <= w_frame;
    end else begin
      r_frame   <= 1'b0;
    end
  end

  assign display_o        = r_display;
  assign dp_o             = r_dp;
  assign display_select_o = r_select;
  assign frame_o          = r_frame;

endmodule

// File: doc/module_seg7_scan_n.md
# module_seg7_scan_n

Parametrised, double-buffered 7-segment scan controller for N hexadecimal digits, with per-digit decimal points, leading-zero blanking and PWM brightness. It sits after the clock generator in the display top level, on the 10 MHz domain. It takes two candidate display words and a source select, and drives the multiplexed active-low segment and anode lines. Display updates are tear-free because a new value only becomes visible at a frame boundary.

## Interface
- N_DIGITS, 8: number of digits scanned; legal 2..16.
- DIGIT_CYCLES, 10000: enabled clock cycles per digit slot (1 ms at 10 MHz); legal ≥ 2^PWM_BITS.
- PWM_BITS, 4: brightness resolution in bits.

- clk_i  in  1  system clock (10 MHz domain).
- rst_n_i  in  1  asynchronous, active-low reset.
- clk_en_i  in  1  clock enable; when low, all state holds.
- wr_en_i  in  1  load the selected word into the shadow buffer (qualified by clk_en_i).
- sel_i  in  1  source select: 0 = data_a_i, 1 = data_b_i.
- data_a_i  in  4*N_DIGITS  display word A; nibble i → digit i.
- data_b_i  in  4*N_DIGITS  display word B.
- dp_i  in  N_DIGITS  decimal-point enables, captured with the data.
- blank_lz_i  in  1  enable leading-zero blanking.
- bright_i  in  PWM_BITS  brightness; duty = (bright_i+1)/2^PWM_BITS.
- display_o  out  7  segments a..g (bit 0 = a), active-low.
- dp_o  out  1  decimal point, active-low.
- display_select_o  out  N_DIGITS  anodes, one-hot active-low.
- frame_o  out  1  one-cycle pulse at each frame boundary.

## Operation
- Shadow buffer: data plus dp, 4N+N bits. When wr_en_i & clk_en_i, it loads the word chosen by sel_i together with dp_i, and sets pending.
- Active buffer: copied from the shadow when pending is set at a frame boundary; pending then clears.
- Scan timer counts 0..DIGIT_CYCLES-1 on each enabled cycle. When it wraps, digit index d advances; N_DIGITS-1 wraps to 0.
- Frame boundary: the enabled cycle where the timer wraps and d = N_DIGITS-1.
- PWM counter: free-running PWM_BITS-bit counter on enabled cycles. The anode is on while pwm_cnt ≤ bright_i. At maximum bright_i the anode is always on.
- Segment decode: hex 0-F, standard glyphs (b, d lowercase), driven active-low. dp_o = ~dp of digit d.
- Leading-zero blanking (blank_lz_i = 1): scanning from digit N-1 downward, a digit is blanked while its nibble is 0 and its dp bit is 0. Blanking stops at the first digit that fails this test. Digit 0 is never blanked.
- A blanked digit has its anode off for the whole slot.
- The blanking mask is evaluated on the active buffer only.
- Changing bright_i or blank_lz_i takes effect immediately (next registered output). It does not wait for a frame boundary.

## Timing
- Reset values:
  - Shadow and active buffers = 0; pending = 0.
  - Timer, d and pwm_cnt = 0.
  - display_o = 7'h7F, dp_o = 1, display_select_o all ones, frame_o = 0.
- All outputs are registered: one cycle of latency from counter/buffer state to pins.
- Write to shadow visibility:
  - A write at cycle t updates the shadow at t+1.
  - It appears on the pins one cycle after the next frame boundary.
  - Worst-case latency is N_DIGITS*DIGIT_CYCLES+2 enabled cycles.
- Write on the frame-boundary cycle: the active buffer takes the pre-write shadow contents. The new write stays pending for the following frame.
- Back-to-back writes within a frame: the last one wins; only one transfer happens.
- clk_en_i low: timer, PWM, digit index, buffers and outputs all hold. frame_o is 0 while disabled.
- Reset asserted mid-frame: outputs go to their off values asynchronously, and any pending write is discarded.

## Test plan
Bench parameters: N_DIGITS=8, DIGIT_CYCLES=8, PWM_BITS=2, clk_en_i=1 unless stated.

1. Reset release → display_select_o = 8'hFE, then 8'hFD, and so on.
   - Anode advances every 8 cycles; frame_o pulses once per 64 cycles.
   - Digit 0 shows 0 (display_o = 7'h40).
2. sel_i=1, data_b_i=32'h0000_00A5, wr_en_i for 1 cycle mid-frame, blank_lz_i=1.
   - No change until the frame boundary.
   - Next frame: digit 0 shows 5, digit 1 shows A, digits 7..2 have their anodes off.
3. Same data with blank_lz_i=0 → all 8 anodes scan, digits 7..2 show 0. Then dp_i=8'h10 with blank_lz_i=1 → digits 4..0 visible, dp_o=0 on digit 4 only.
4. Write data_a_i=32'h1234_5678 on the exact frame-boundary cycle → the old value stays for one more frame, then 1234_5678 appears.
5. bright_i=2'd1 → the active anode is low 2 of every 4 cycles. bright_i=2'd3 → 100% duty.
6. clk_en_i held low for 20 cycles mid-slot → outputs are frozen; the slot resumes with the remaining count. Then assert rst_n_i mid-frame → outputs off immediately, and the pending write is lost.
